// File: rtl/frame_swap_controller.sv
// rtl/frame_swap_controller.sv - N-bank frame manager: display/write bank ownership and loaded-frame FIFO
module frame_swap_controller #(
  parameter int BUFFERS     = 2,
  parameter int DROP_OLDEST = 0,
  parameter int COUNT_WIDTH = 8,
  parameter int IW          = $clog2(BUFFERS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic                     frame_complete,
  input  logic                     loaded,
  output logic                     ready,
  output logic [IW-1:0]            wbuf,
  output logic [IW-1:0]            rbuf,
  output logic                     swapped,
  output logic [$clog2(BUFFERS):0] queue_level,
  output logic [COUNT_WIDTH-1:0]   dropped_count
);
  localparam int QW      = $clog2(BUFFERS) + 1;
  localparam int DEPTH   = BUFFERS - 1;
  localparam bit DROP_EN = (DROP_OLDEST != 0) && (BUFFERS >= 3);

  logic [IW-1:0]          rbuf_q, rbuf_d;
  logic [IW-1:0]          wbuf_q, wbuf_d;
  logic                   ready_q, ready_d;
  logic                   swapped_q;
  logic [IW-1:0]          queue_q [DEPTH];
  logic [IW-1:0]          queue_d [DEPTH];
  logic [QW-1:0]          level_q, level_d;
  logic [BUFFERS-1:0]     free_q, free_d;
  logic [COUNT_WIDTH-1:0] dropped_q, dropped_d;
  logic                   swap, load, found;
  logic [IW-1:0]          pick;

  always_comb begin
    swap      = (level_q != '0) && (frame_complete || mode);
    load      = loaded && ready_q;
    rbuf_d    = rbuf_q;
    wbuf_d    = wbuf_q;
    ready_d   = ready_q;
    queue_d   = queue_q;
    level_d   = level_q;
    free_d    = free_q;
    dropped_d = dropped_q;
    found     = 1'b0;
    pick      = '0;

    // Swap pops the pre-edge head before any same-edge load is pushed.
    if (swap) begin
      rbuf_d = queue_q[0];
      for (int i = 0; i < DEPTH - 1; i++) queue_d[i] = queue_q[i + 1];
      level_d = level_q - QW'(1);
      if (ready_q) begin
        free_d[rbuf_q] = 1'b1;
      end else begin
        wbuf_d  = rbuf_q;
        ready_d = 1'b1;
      end
    end

    if (load) begin
      for (int i = 0; i < DEPTH; i++)
        if (QW'(i) == level_d) queue_d[i] = wbuf_q;
      level_d = level_d + QW'(1);
      for (int i = 0; i < BUFFERS; i++)
        if (free_d[i] && !found) begin
          found = 1'b1;
          pick  = IW'(i);
        end
      if (found) begin
        wbuf_d       = pick;
        free_d[pick] = 1'b0;
      end else if (DROP_EN) begin
        // Reclaim the oldest never-displayed frame as the new write bank.
        wbuf_d = queue_d[0];
        for (int i = 0; i < DEPTH - 1; i++) queue_d[i] = queue_d[i + 1];
        level_d = level_d - QW'(1);
        if (dropped_q != '1) dropped_d = dropped_q + COUNT_WIDTH'(1);
      end else begin
        ready_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rbuf_q    <= '0;
      wbuf_q    <= IW'(1);
      ready_q   <= 1'b1;
      swapped_q <= 1'b0;
      level_q   <= '0;
      free_q    <= ~BUFFERS'(3);
      dropped_q <= '0;
      for (int i = 0; i < DEPTH; i++) queue_q[i] <= '0;
    end else begin
      rbuf_q    <= rbuf_d;
      wbuf_q    <= wbuf_d;
      ready_q   <= ready_d;
      swapped_q <= swap;
      level_q   <= level_d;
      free_q    <= free_d;
      dropped_q <= dropped_d;
      queue_q   <= queue_d;
    end
  end

  assign ready         = ready_q;
  assign wbuf          = wbuf_q;
  assign rbuf          = rbuf_q;
  assign swapped       = swapped_q;
  assign queue_level   = level_q;
  assign dropped_count = dropped_q;
endmodule
